stack_shiftreg: RTL and testbench

- Parametrised LIFO stack of WIDTH-bit words, built as a DEPTH-entry word-wide shift register; the next generation of the single-bit shift register.
- Entry 0 is the top of stack. Each operation shifts the whole array one word toward the top or the bottom, or permutes the top entries.
- Serves as the operand stack feeding the calculator ALU. Exposes the top two entries, an occupancy count and a sticky error flag.

---
 rtl/stack_shiftreg.sv | 127 ++++++++++++
 tb/tb_stack_shiftreg.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/stack_shiftreg.sv
// rtl/stack_shiftreg.sv - LIFO operand stack as a word-wide shift register, entry 0 is top.
// Optional ROT op (110) is enabled by defining STACK_SHIFTREG_ROT_EN; otherwise 110 is a NOP.
module stack_shiftreg #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             err
);

  localparam logic [2:0] OP_NOP    = 3'b000;
  localparam logic [2:0] OP_PUSH   = 3'b001;
  localparam logic [2:0] OP_POP    = 3'b010;
  localparam logic [2:0] OP_DUP    = 3'b011;
  localparam logic [2:0] OP_SWAP   = 3'b100;
  localparam logic [2:0] OP_OVER   = 3'b101;
  localparam logic [2:0] OP_ROT    = 3'b110;
  localparam logic [2:0] OP_CLRERR = 3'b111;

  logic [WIDTH-1:0] e_q [DEPTH];
  logic [WIDTH-1:0] e_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             err_q, err_d;

  logic             has1, has2, room;
  logic             do_push;
  logic [WIDTH-1:0] push_val;

  assign has1 = (count_q >= CW'(1));
  assign has2 = (count_q >= CW'(2));
  assign room = (count_q <  CW'(DEPTH));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) e_d[i] = e_q[i];
    count_d  = count_q;
    err_d    = err_q;
    do_push  = 1'b0;
    push_val = din;

    if (en) begin
      case (op)
        OP_NOP: ;
        OP_PUSH: begin
          if (room) do_push = 1'b1;
          else      err_d   = 1'b1;
        end
        OP_POP: begin
          if (has1) begin
            for (int i = 0; i < DEPTH - 1; i++) e_d[i] = e_q[i+1];
            e_d[DEPTH-1] = '0;
            count_d      = count_q - CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        OP_DUP: begin
          push_val = e_q[0];
          if (has1 && room) do_push = 1'b1;
          else              err_d   = 1'b1;
        end
        OP_SWAP: begin
          if (has2) begin
            e_d[0] = e_q[1];
            e_d[1] = e_q[0];
          end else begin
            err_d = 1'b1;
          end
        end
        OP_OVER: begin
          push_val = e_q[1];
          if (has2 && room) do_push = 1'b1;
          else              err_d   = 1'b1;
        end
`ifdef STACK_SHIFTREG_ROT_EN
        OP_ROT: begin
          if (count_q >= CW'(3)) begin
            e_d[0] = e_q[2];
            e_d[1] = e_q[0];
            e_d[2] = e_q[1];
          end else begin
            err_d = 1'b1;
          end
        end
`endif
        OP_CLRERR: err_d = 1'b0;
        default: ;
      endcase
    end

    // A rejected push never reaches here, so the bottom entry shifted out is always invalid (zero).
    if (do_push) begin
      for (int i = DEPTH - 1; i > 0; i--) e_d[i] = e_q[i-1];
      e_d[0]  = push_val;
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) e_q[i] <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) e_q[i] <= e_d[i];
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign tos   = e_q[0];
  assign nos   = e_q[1];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign err   = err_q;

endmodule

// File: tb/tb_stack_shiftreg.sv
// tb/tb_stack_shiftreg.sv - directed self-checking bench for stack_shiftreg (WIDTH=4, DEPTH=8).
module tb_stack_shiftreg;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [2:0] op  = 3'b000;
  logic [3:0] din = 4'h0;
  logic [3:0] tos, nos;
  logic [3:0] count;
  logic       empty, full, err;

  int checks = 0;
  int fails  = 0;

  localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, POP = 3'b010, DUP = 3'b011;
  localparam logic [2:0] SWAP = 3'b100, OVER = 3'b101, ROT = 3'b110, CLRERR = 3'b111;

  stack_shiftreg #(.WIDTH(4), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .din(din),
    .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full), .err(err)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [2:0] o, input logic [3:0] d);
    @(negedge clk);
    en = 1'b1; op = o; din = d;
    @(posedge clk);
    #1;
    en = 1'b0; op = NOP;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    checks++; if (tos !== 4'd0)   begin fails++; $display("FAIL reset_tos got %0d want 0", tos); end
    checks++; if (nos !== 4'd0)   begin fails++; $display("FAIL reset_nos got %0d want 0", nos); end
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", empty); end
    checks++; if (full !== 1'b0)  begin fails++; $display("FAIL reset_full got %b want 0", full); end
    checks++; if (err !== 1'b0)   begin fails++; $display("FAIL reset_err got %b want 0", err); end
  endtask

  task automatic test_push_pop();
    logic [3:0] exp_tos [3] = '{4'd5, 4'd3, 4'd0};
    logic [3:0] exp_nos [3] = '{4'd3, 4'd0, 4'd0};
    do_reset();
    do_op(PUSH, 4'd3); do_op(PUSH, 4'd5); do_op(PUSH, 4'd9);
    checks++; if (tos !== 4'd9)   begin fails++; $display("FAIL pp_tos got %0d want 9", tos); end
    checks++; if (nos !== 4'd5)   begin fails++; $display("FAIL pp_nos got %0d want 5", nos); end
    checks++; if (count !== 4'd3) begin fails++; $display("FAIL pp_count got %0d want 3", count); end
    checks++; if (empty !== 1'b0) begin fails++; $display("FAIL pp_empty got %b want 0", empty); end
    checks++; if (err !== 1'b0)   begin fails++; $display("FAIL pp_err got %b want 0", err); end
    for (int k = 0; k < 3; k++) begin
      do_op(POP, 4'd0);
      checks++; if (tos !== exp_tos[k]) begin fails++; $display("FAIL pop%0d_tos got %0d want %0d", k, tos, exp_tos[k]); end
      checks++; if (nos !== exp_nos[k]) begin fails++; $display("FAIL pop%0d_nos got %0d want %0d", k, nos, exp_nos[k]); end
    end
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL pp_end_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL pp_end_empty got %b want 1", empty); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      checks++; if (full !== 1'b0) begin fails++; $display("FAIL fill%0d_full got %b want 0", k, full); end
      do_op(PUSH, 4'(k));
    end
    checks++; if (full !== 1'b1)  begin fails++; $display("FAIL full_flag got %b want 1", full); end
    checks++; if (tos !== 4'd8)   begin fails++; $display("FAIL full_tos got %0d want 8", tos); end
    do_op(PUSH, 4'd15);
    checks++; if (err !== 1'b1)   begin fails++; $display("FAIL ovf_err got %b want 1", err); end
    checks++; if (tos !== 4'd8)   begin fails++; $display("FAIL ovf_tos got %0d want 8", tos); end
    checks++; if (count !== 4'd8) begin fails++; $display("FAIL ovf_count got %0d want 8", count); end
    for (int k = 0; k < 8; k++) begin
      checks++; if (tos !== 4'(8 - k)) begin fails++; $display("FAIL drain%0d_tos got %0d want %0d", k, tos, 8 - k); end
      do_op(POP, 4'd0);
      if (k == 0) begin
        checks++; if (full !== 1'b0) begin fails++; $display("FAIL unfull got %b want 0", full); end
      end
    end
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL drain_count got %0d want 0", count); end
    checks++; if (tos !== 4'd0)   begin fails++; $display("FAIL drain_tos got %0d want 0", tos); end
  endtask

  task automatic test_underflow();
    do_reset();
    do_op(POP, 4'd0);
    checks++; if (err !== 1'b1)   begin fails++; $display("FAIL udf_err got %b want 1", err); end
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL udf_count got %0d want 0", count); end
    checks++; if (empty !== 1'b1) begin fails++; $display("FAIL udf_empty got %b want 1", empty); end
    do_op(NOP, 4'd0);
    checks++; if (err !== 1'b1)   begin fails++; $display("FAIL err_sticky got %b want 1", err); end
    do_op(CLRERR, 4'd0);
    checks++; if (err !== 1'b0)   begin fails++; $display("FAIL clrerr got %b want 0", err); end
    do_op(PUSH, 4'd4);
    do_op(SWAP, 4'd0);
    checks++; if (err !== 1'b1)   begin fails++; $display("FAIL swap1_err got %b want 1", err); end
    checks++; if (tos !== 4'd4)   begin fails++; $display("FAIL swap1_tos got %0d want 4", tos); end
    checks++; if (count !== 4'd1) begin fails++; $display("FAIL swap1_count got %0d want 1", count); end
    do_op(PUSH, 4'd7);
    checks++; if (count !== 4'd2 || tos !== 4'd7) begin fails++; $display("FAIL push_with_err got count %0d tos %0d want 2 7", count, tos); end
  endtask

  task automatic test_permute();
    do_reset();
    do_op(PUSH, 4'd2); do_op(PUSH, 4'd6);
    do_op(SWAP, 4'd0);
    checks++; if (tos !== 4'd2)   begin fails++; $display("FAIL swap_tos got %0d want 2", tos); end
    checks++; if (nos !== 4'd6)   begin fails++; $display("FAIL swap_nos got %0d want 6", nos); end
    do_op(DUP, 4'd0);
    checks++; if (tos !== 4'd2 || nos !== 4'd2) begin fails++; $display("FAIL dup_top got %0d/%0d want 2/2", tos, nos); end
    checks++; if (count !== 4'd3) begin fails++; $display("FAIL dup_count got %0d want 3", count); end
    do_op(OVER, 4'd0);
    checks++; if (tos !== 4'd2 || nos !== 4'd2) begin fails++; $display("FAIL over_top got %0d/%0d want 2/2", tos, nos); end
    checks++; if (count !== 4'd4) begin fails++; $display("FAIL over_count got %0d want 4", count); end
    do_op(POP, 4'd0); do_op(POP, 4'd0);
    checks++; if (tos !== 4'd2 || nos !== 4'd6) begin fails++; $display("FAIL permute_rest got %0d/%0d want 2/6", tos, nos); end
    checks++; if (err !== 1'b0)   begin fails++; $display("FAIL permute_err got %b want 0", err); end
  endtask

  task automatic test_rot();
    do_reset();
    do_op(PUSH, 4'd1); do_op(PUSH, 4'd2); do_op(PUSH, 4'd3);
    do_op(ROT, 4'd0);
`ifdef STACK_SHIFTREG_ROT_EN
    checks++; if (tos !== 4'd1 || nos !== 4'd3) begin fails++; $display("FAIL rot_top got %0d/%0d want 1/3", tos, nos); end
    do_op(POP, 4'd0); do_op(POP, 4'd0);
    checks++; if (tos !== 4'd2) begin fails++; $display("FAIL rot_e2 got %0d want 2", tos); end
`else
    checks++; if (tos !== 4'd3 || nos !== 4'd2) begin fails++; $display("FAIL rot_nop_top got %0d/%0d want 3/2", tos, nos); end
    checks++; if (err !== 1'b0 || count !== 4'd3) begin fails++; $display("FAIL rot_nop_state got err %b count %0d want 0 3", err, count); end
`endif
  endtask

  task automatic test_rst_priority();
    do_reset();
    do_op(POP, 4'd0);
    for (int k = 0; k < 5; k++) do_op(PUSH, 4'(k + 10));
    checks++; if (count !== 4'd5) begin fails++; $display("FAIL pre_rst_count got %0d want 5", count); end
    @(negedge clk);
    rst = 1'b1; en = 1'b1; op = PUSH; din = 4'd9;
    @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b0; op = NOP;
    checks++; if (count !== 4'd0) begin fails++; $display("FAIL rstpri_count got %0d want 0", count); end
    checks++; if (tos !== 4'd0)   begin fails++; $display("FAIL rstpri_tos got %0d want 0", tos); end
    checks++; if (err !== 1'b0)   begin fails++; $display("FAIL rstpri_err got %b want 0", err); end
  endtask

  task automatic test_hold();
    do_reset();
    do_op(PUSH, 4'd11); do_op(PUSH, 4'd13);
    @(negedge clk);
    en = 1'b0; op = PUSH; din = 4'd7;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (tos !== 4'd13 || nos !== 4'd11 || count !== 4'd2)
        begin fails++; $display("FAIL hold%0d got %0d/%0d/%0d want 13/11/2", k, tos, nos, count); end
    end
    op = NOP;
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_full();
    test_underflow();
    test_permute();
    test_rot();
    test_rst_priority();
    test_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
